alu_8bit: RTL and testbench



---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_datapath.sv | 46 ++++
 rtl/alu_8bit.sv | 31 +++
 tb/tb_alu_8bit.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, flag indices and widths for the 8-bit ALU
package alu_pkg;
  localparam int DW = 8;
  localparam int OW = 4;
  localparam int FW = 5;
  localparam logic [OW-1:0] OP_ADD  = 4'd0;
  localparam logic [OW-1:0] OP_SUB  = 4'd1;
  localparam logic [OW-1:0] OP_INC  = 4'd2;
  localparam logic [OW-1:0] OP_DEC  = 4'd3;
  localparam logic [OW-1:0] OP_SHL  = 4'd4;
  localparam logic [OW-1:0] OP_SHR  = 4'd5;
  localparam logic [OW-1:0] OP_ROL  = 4'd6;
  localparam logic [OW-1:0] OP_ROR  = 4'd7;
  localparam logic [OW-1:0] OP_AND  = 4'd8;
  localparam logic [OW-1:0] OP_OR   = 4'd9;
  localparam logic [OW-1:0] OP_XOR  = 4'd10;
  localparam logic [OW-1:0] OP_NOR  = 4'd11;
  localparam logic [OW-1:0] OP_NAND = 4'd12;
  localparam logic [OW-1:0] OP_NEG  = 4'd13;
  localparam logic [OW-1:0] OP_NOP  = 4'd14;
  localparam logic [OW-1:0] OP_SWAP = 4'd15;
  localparam int FLG_EQUAL   = 4;
  localparam int FLG_ZERO    = 3;
  localparam int FLG_CARRY   = 2;
  localparam int FLG_PARITY  = 1;
  localparam int FLG_COMPARE = 0;
endpackage

// File: rtl/alu_datapath.sv
// alu_datapath: combinational next result, carry and flags from a, b and opcode
module alu_datapath
  import alu_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [OW-1:0] opcode,
  output logic [DW-1:0] res,
  output logic [FW-1:0] flg
);
  logic [DW:0] sum;
  logic        carry;
  assign sum = {1'b0, a} + {1'b0, b};
  // result and carry per opcode; NOP output is ignored by the register stage
  always_comb begin
    res   = '0;
    carry = 1'b0;
    case (opcode)
      OP_ADD:  {carry, res} = sum;
      OP_SUB:  {carry, res} = {a < b, a - b};
      OP_INC:  {carry, res} = {a == 8'hff, a + 8'd1};
      OP_DEC:  {carry, res} = {a == 8'h00, a - 8'd1};
      OP_SHL:  {carry, res} = {a[7], a[6:0], 1'b0};
      OP_SHR:  {carry, res} = {a[0], 1'b0, a[7:1]};
      OP_ROL:  {carry, res} = {a[7], a[6:0], a[7]};
      OP_ROR:  {carry, res} = {a[0], a[0], a[7:1]};
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOR:  res = ~(a | b);
      OP_NAND: res = ~(a & b);
      OP_NEG:  {carry, res} = {a != 8'h00, 8'h00 - a};
      OP_SWAP: res = {a[3:0], a[7:4]};
      default: res = '0;
    endcase
  end
  // status flags: EQUAL/COMPARE from operands, the rest from the result
  always_comb begin
    flg              = '0;
    flg[FLG_EQUAL]   = a == b;
    flg[FLG_ZERO]    = res == '0;
    flg[FLG_CARRY]   = carry;
    flg[FLG_PARITY]  = ^res;
    flg[FLG_COMPARE] = a > b;
  end
endmodule

// File: rtl/alu_8bit.sv
// alu_8bit: registered 8-bit ALU with status flags and NOP hold
module alu_8bit
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [OW-1:0] opcode,
  output logic [DW-1:0] out,
  output logic [FW-1:0] flags
);
  logic [DW-1:0] res;
  logic [FW-1:0] flg;
  alu_datapath u_dp (
    .a      (a),
    .b      (b),
    .opcode (opcode),
    .res    (res),
    .flg    (flg)
  );
  // result/flag registers; NOP keeps the previous contents
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out   <= '0;
      flags <= '0;
    end else if (opcode != OP_NOP) begin
      out   <= res;
      flags <= flg;
    end
endmodule

// File: tb/tb_alu_8bit.sv
// tb_alu_8bit: directed and random scoreboard checks of alu_8bit
module tb_alu_8bit;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a, b, out;
  logic [3:0] opcode;
  logic [4:0] flags;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [7:0] o;
    logic [4:0] f;
    string      tag;
  } exp_t;
  exp_t sb[$];
  logic [7:0] last_o;
  logic [4:0] last_f;

  alu_8bit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .opcode (opcode),
    .out    (out),
    .flags  (flags)
  );

  always #5 clk = ~clk;

  task automatic check_now(input logic [7:0] eo, input logic [4:0] ef, input string tag);
    total++;
    assert (out === eo && flags === ef)
    else begin
      bad++;
      $error("FAIL %s: out=%h flags=%b expected out=%h flags=%b", tag, out, flags, eo, ef);
    end
  endtask

  task automatic step(input logic [7:0] ta, input logic [7:0] tb_, input logic [3:0] op,
                      input logic [7:0] eo, input logic [4:0] ef, input string tag);
    exp_t e;
    a = ta;
    b = tb_;
    opcode = op;
    sb.push_back('{eo, ef, tag});
    last_o = eo;
    last_f = ef;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_now(e.o, e.f, e.tag);
  endtask

  function automatic void model(input int x, input int y, input int op,
                                output logic [7:0] o, output logic [4:0] f);
    int r, c, ones;
    c = 0;
    case (op)
      0: begin r = x + y; c = (r > 255) ? 1 : 0; end
      1: begin r = x - y; c = (x < y) ? 1 : 0; end
      2: begin r = x + 1; c = (x == 255) ? 1 : 0; end
      3: begin r = x - 1; c = (x == 0) ? 1 : 0; end
      4: begin r = x * 2; c = x / 128; end
      5: begin r = x / 2; c = x % 2; end
      6: begin r = x * 2 + x / 128; c = x / 128; end
      7: begin r = x / 2 + (x % 2) * 128; c = x % 2; end
      8: r = x & y;
      9: r = x | y;
      10: r = x ^ y;
      11: r = ~(x | y);
      12: r = ~(x & y);
      13: begin r = -x; c = (x != 0) ? 1 : 0; end
      default: r = (x % 16) * 16 + x / 16;
    endcase
    r = r & 255;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += (r >> i) & 1;
    o = 8'(r);
    f = {x == y, r == 0, c[0], ones[0], x > y};
  endfunction

  task automatic step_model(input logic [7:0] ta, input logic [7:0] tb_, input logic [3:0] op);
    logic [7:0] eo;
    logic [4:0] ef;
    if (op == 4'd14) begin
      eo = last_o;
      ef = last_f;
    end else model(int'(ta), int'(tb_), int'(op), eo, ef);
    step(ta, tb_, op, eo, ef, $sformatf("rand op=%0d a=%0d b=%0d", op, ta, tb_));
  endtask

  initial begin
    rst_n = 1'b0;
    a = 8'd36;
    b = 8'd58;
    opcode = 4'd0;
    last_o = '0;
    last_f = '0;
    #2;
    check_now(8'h00, 5'b00000, "reset_async");
    @(posedge clk);
    #1;
    check_now(8'h00, 5'b00000, "reset_held_over_edge");
    rst_n = 1'b1;
    step(8'd1, 8'd2, 4'd14, 8'h00, 5'b00000, "nop_after_reset");
    a = 8'd36;
    b = 8'd58;
    opcode = 4'd0;
    #1;
    check_now(8'h00, 5'b00000, "add_not_before_edge");
    step(8'd36, 8'd58, 4'd0, 8'd94, 5'b00010, "add_36_58");
    step(8'd250, 8'd250, 4'd0, 8'd244, 5'b10110, "add_250_250");
    step(8'd137, 8'd26, 4'd1, 8'd111, 5'b00001, "sub_137_26");
    step(8'd26, 8'd137, 4'd1, 8'd145, 5'b00110, "sub_26_137");
    step(8'd255, 8'd137, 4'd2, 8'd0, 5'b01101, "inc_255");
    step(8'd0, 8'd0, 4'd3, 8'd255, 5'b10100, "dec_0");
    step(8'b10101010, 8'd0, 4'd4, 8'b01010100, 5'b00111, "shl");
    step(8'b10101010, 8'd0, 4'd6, 8'b01010101, 5'b00101, "rol");
    step(8'b01010101, 8'd0, 4'd5, 8'b00101010, 5'b00111, "shr");
    step(8'b01010101, 8'd0, 4'd7, 8'b10101010, 5'b00101, "ror");
    step(8'b01010110, 8'b00100010, 4'd8, 8'b00000010, 5'b00011, "and");
    step(8'b01010110, 8'b00100010, 4'd9, 8'b01110110, 5'b00011, "or");
    step(8'b01010110, 8'b00100010, 4'd10, 8'b01110100, 5'b00001, "xor");
    step(8'b01010110, 8'b00100010, 4'd11, 8'b10001001, 5'b00011, "nor");
    step(8'b01010110, 8'b00100010, 4'd12, 8'b11111101, 5'b00011, "nand");
    step(8'd15, 8'd0, 4'd13, 8'd241, 5'b00111, "neg_15");
    step(8'b01011010, 8'd0, 4'd15, 8'b10100101, 5'b00001, "swap");
    step(8'hff, 8'h00, 4'd14, 8'b10100101, 5'b00001, "nop_hold_1");
    step(8'h00, 8'hff, 4'd14, 8'b10100101, 5'b00001, "nop_hold_2");
    step(8'h33, 8'h33, 4'd14, 8'b10100101, 5'b00001, "nop_hold_3");
    a = 8'd1;
    b = 8'd1;
    opcode = 4'd0;
    #2;
    rst_n = 1'b0;
    #1;
    check_now(8'h00, 5'b00000, "reset_midstream");
    last_o = '0;
    last_f = '0;
    #1;
    rst_n = 1'b1;
    step(8'd9, 8'd9, 4'd14, 8'h00, 5'b00000, "nop_after_midreset");
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom_range(0, 255));
      step_model(ra, rb, 4'($urandom_range(0, 15)));
    end
    for (int k = 0; k < 16; k++) step_model(8'd0, 8'd255, 4'(k));
    for (int k = 0; k < 16; k++) step_model(8'd255, 8'd255, 4'(k));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
